// File: rtl/multirate_mac_scheduler.sv
// multirate_mac_scheduler: round-robin sharing of one external multiplier among polyphase FIR branches, with per-branch accumulators.
// Optional MR_MAC_SAT_EN: saturate the scaled result to OUT_W instead of wrapping.
module multirate_mac_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DIN_W = 16,
  parameter int COEF_W = 10,
  parameter int PROD_W = 26,
  parameter int ACC_W = 32,
  parameter int TAPS = 8,
  parameter int SHIFT = 9,
  parameter int OUT_W = 16
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        clr,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DIN_W-1:0]    req_data,
  input  logic [NUM_REQ*COEF_W-1:0]   req_coef,
  output logic [DIN_W-1:0]            mul_din0,
  output logic [COEF_W-1:0]           mul_din1,
  input  logic [PROD_W-1:0]           mul_dout,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_W-1:0]            out_data,
  output logic [$clog2(NUM_REQ)-1:0]  out_id
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int TC_W = $clog2(TAPS);
  localparam logic signed [ACC_W-1:0] OMAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OMIN = ~OMAX;
  logic [ID_W-1:0] ptr, gid, p1_id;
  logic any, go, stall, last, p1_vld, p1_last;
  logic [PROD_W-1:0] p1_prod;
  logic signed [ACC_W-1:0] acc [NUM_REQ];
  logic [TC_W-1:0] cnt [NUM_REQ];
  logic signed [ACC_W-1:0] sum, scaled;
  logic [OUT_W-1:0] res;
  int idx;
  // Descending scan so the last hit is the first valid at or above ptr.
  always_comb begin
    any = 1'b0;
    gid = '0;
    idx = 0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        any = 1'b1;
        gid = ID_W'(idx);
      end
    end
  end
  assign stall = out_valid & ~out_ready;
  assign go = any & ~stall & ~clr & ap_rst_n;
  assign req_ready = go ? (NUM_REQ'(1) << gid) : '0;
  assign mul_din0 = go ? req_data[gid*DIN_W +: DIN_W] : '0;
  assign mul_din1 = go ? req_coef[gid*COEF_W +: COEF_W] : '0;
  assign last = cnt[gid] == TC_W'(TAPS-1);
  assign sum = acc[p1_id] + {{(ACC_W-PROD_W){p1_prod[PROD_W-1]}}, p1_prod};
  assign scaled = sum >>> SHIFT;
`ifdef MR_MAC_SAT_EN
  assign res = scaled > OMAX ? OMAX[OUT_W-1:0] : scaled < OMIN ? OMIN[OUT_W-1:0] : OUT_W'(scaled);
`else
  assign res = OUT_W'(scaled);
`endif
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ptr <= '0;
      p1_vld <= 1'b0;
      p1_prod <= '0;
      p1_id <= '0;
      p1_last <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_id <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else if (clr) begin
      ptr <= '0;
      p1_vld <= 1'b0;
      out_valid <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else if (!stall) begin
      p1_vld <= go;
      if (go) begin
        p1_prod <= mul_dout;
        p1_id <= gid;
        p1_last <= last;
        cnt[gid] <= last ? '0 : cnt[gid] + 1'b1;
        ptr <= gid == ID_W'(NUM_REQ-1) ? '0 : gid + 1'b1;
      end
      if (p1_vld) acc[p1_id] <= p1_last ? '0 : sum;
      out_valid <= p1_vld & p1_last;
      if (p1_vld & p1_last) begin
        out_data <= res;
        out_id <= p1_id;
      end
    end
  end
endmodule

// File: tb/tb_multirate_mac_scheduler.sv
// tb_multirate_mac_scheduler: randomized and directed checks of the MAC scheduler against a behavioural model.
module tb_multirate_mac_scheduler;
  localparam int N = 4;
  localparam int TAPS = 8;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, out_ready = 1'b1;
  logic [N-1:0] vld = '0, req_ready;
  logic signed [15:0] dat [N];
  logic signed [9:0] cf [N];
  logic [N*16-1:0] rdata;
  logic [N*10-1:0] rcoef;
  logic [15:0] din0, out_data;
  logic [9:0] din1;
  logic [25:0] dout;
  logic out_valid;
  logic [1:0] out_id;
  int tests = 0, fails = 0;
  int acc [N] = '{default: 0};
  int cnt [N] = '{default: 0};
  int ptr = 0, mi = 0, pid = 0;
  bit mv = 0, pv = 0;
  logic [15:0] md = '0, pval = '0;

  multirate_mac_scheduler dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .clr(clr), .req_valid(vld), .req_ready(req_ready),
    .req_data(rdata), .req_coef(rcoef), .mul_din0(din0), .mul_din1(din1), .mul_dout(dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id)
  );

  always #5 clk = ~clk;
  assign dout = $signed(din0) * $signed(din1);
  always_comb begin
    rdata = '0;
    rcoef = '0;
    for (int i = 0; i < N; i++) begin
      rdata[i*16 +: 16] = dat[i];
      rcoef[i*10 +: 10] = cf[i];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] scale(input int s);
    int q;
    q = s >>> 9;
`ifdef MR_MAC_SAT_EN
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
`endif
    return q[15:0];
  endfunction

  // Model: accumulates at grant time; completed results take one extra stage before the output register.
  always @(negedge clk) begin
    int g;
    bit st;
    logic [N-1:0] er;
    logic [15:0] e0;
    logic [9:0] e1;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin acc[i] = 0; cnt[i] = 0; end
      ptr = 0; mv = 0; pv = 0;
    end
    st = mv & ~out_ready;
    g = -1;
    if (rst_n && !clr && !st)
      for (int k = N-1; k >= 0; k--) if (vld[(ptr+k)%N]) g = (ptr+k)%N;
    er = '0; e0 = '0; e1 = '0;
    if (g >= 0) begin er[g] = 1'b1; e0 = dat[g]; e1 = cf[g]; end
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("mul_din0", 64'(din0), 64'(e0));
    chk("mul_din1", 64'(din1), 64'(e1));
    chk("out_valid", 64'(out_valid), 64'(mv));
    if (mv) begin
      chk("out_data", 64'(out_data), 64'(md));
      chk("out_id", 64'(out_id), 64'(mi));
    end
    if (rst_n && clr) begin
      for (int i = 0; i < N; i++) begin acc[i] = 0; cnt[i] = 0; end
      ptr = 0; mv = 0; pv = 0;
    end else if (rst_n && !st) begin
      mv = pv;
      if (pv) begin md = pval; mi = pid; end
      pv = 0;
      if (g >= 0) begin
        acc[g] += int'(dat[g]) * int'(cf[g]);
        cnt[g]++;
        if (cnt[g] == TAPS) begin
          pv = 1; pval = scale(acc[g]); pid = g; acc[g] = 0; cnt[g] = 0;
        end
        ptr = (g + 1) % N;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_out(output logic [15:0] d, output logic [1:0] id, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 64);
    chk("wait_out_valid", 64'(out_valid), 64'd1);
    d = out_data;
    id = out_id;
    cyc(1);
  endtask

  initial begin
    logic [15:0] d;
    logic [1:0] id;
    int n;
    for (int i = 0; i < N; i++) begin dat[i] = '0; cf[i] = '0; end
    cyc(3);
    vld = '1;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_id", 64'(out_id), 64'd0);
    chk("rst_din0", 64'(din0), 64'd0);
    chk("rst_din1", 64'(din1), 64'd0);
    vld = '0;
    rst_n = 1'b1;
    cyc(1);
    dat[0] = 100; cf[0] = 64; vld = 4'b0001;
    cyc(8);
    vld = '0;
    wait_out(d, id, n);
    chk("t1_data", 64'(d), 64'd100);
    chk("t1_id", 64'(id), 64'd0);
    chk("t1_latency", 64'(n), 64'd2);
    dat[0] = 1; dat[1] = -1; cf[0] = 511; cf[1] = 511; vld = 4'b0011;
    cyc(16);
    vld = '0;
    wait_out(d, id, n);
    chk("t3_neg_data", 64'(d), 64'hFFF8);
    chk("t3_neg_id", 64'(id), 64'd1);
    wait_out(d, id, n);
    chk("t3_pos_data", 64'(d), 64'd7);
    chk("t3_pos_id", 64'(id), 64'd0);
    dat[3] = 32767; cf[3] = 511; vld = 4'b1000;
    cyc(8);
    vld = '0;
    wait_out(d, id, n);
`ifdef MR_MAC_SAT_EN
    chk("t5_data", 64'(d), 64'h7FFF);
`else
    chk("t5_data", 64'(d), 64'hFDF8);
`endif
    chk("t5_id", 64'(id), 64'd3);
    dat[2] = 100; cf[2] = 64; vld = 4'b0100;
    cyc(8);
    vld = '0; out_ready = 1'b0;
    wait_out(d, id, n);
    chk("t4_data", 64'(d), 64'd100);
    chk("t4_id", 64'(id), 64'd2);
    dat[0] = 16'sd5; cf[0] = 10'sd3; dat[1] = 16'sd9; dat[3] = -16'sd4; vld = 4'b1011;
    repeat (5) begin
      #1;
      chk("t4_stall_ready", 64'(req_ready), 64'd0);
      chk("t4_stall_data", 64'(out_data), 64'd100);
      cyc(1);
    end
    out_ready = 1'b1;
    #1;
    chk("t4_resume", 64'(req_ready), 64'b1000);
    cyc(3);
    vld = '0;
    cyc(2);
    dat[2] = 555; cf[2] = 77; vld = 4'b0100;
    cyc(3);
    clr = 1'b1;
    #1;
    chk("t6_clr_ready", 64'(req_ready), 64'd0);
    cyc(1);
    clr = 1'b0; dat[2] = 100; cf[2] = 64;
    cyc(8);
    vld = '0;
    wait_out(d, id, n);
    chk("t6_data", 64'(d), 64'd100);
    chk("t6_id", 64'(id), 64'd2);
    for (int i = 0; i < 3000; i++) begin
      vld = N'($urandom);
      for (int j = 0; j < N; j++) begin dat[j] = 16'($urandom); cf[j] = 10'($urandom); end
      out_ready = $urandom_range(0, 3) != 0;
      clr = $urandom_range(0, 199) == 0;
      if (i == 1500) begin
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_out_data", 64'(out_data), 64'd0);
        chk("rst_mid_out_id", 64'(out_id), 64'd0);
        chk("rst_mid_req_ready", 64'(req_ready), 64'd0);
        chk("rst_mid_din0", 64'(din0), 64'd0);
        cyc(1);
        rst_n = 1'b1;
      end
      cyc(1);
    end
    vld = '0; clr = 1'b0; out_ready = 1'b1;
    cyc(20);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
